// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction fetch unit
package fetch_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_HOLD  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - memory byte port and decoder handoff bundle for fetch_unit
interface fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int BYTES = 4
);
    logic                      mem_req;
    logic [WIDTH-1:0]          mem_addr;
    logic [BYTE_W-1:0]         mem_rdata;
    logic                      mem_ready;
    logic                      instr_valid;
    logic [BYTE_W*BYTES-1:0]   instr;
    logic [WIDTH-1:0]          instr_pc;
    logic                      instr_ack;

    modport master (
        output mem_req, mem_addr, instr_valid, instr, instr_pc,
        input  mem_rdata, mem_ready, instr_ack
    );

    modport slave (
        input  mem_req, mem_addr, instr_valid, instr, instr_pc,
        output mem_rdata, mem_ready, instr_ack
    );
endinterface

// File: rtl/instr_assembler.sv
// rtl/instr_assembler.sv - byte-lane register bank that assembles one instruction
module instr_assembler
    import fetch_pkg::*;
#(
    parameter int BYTES = 4,
    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    we,
    input  logic [CNT_W-1:0]        sel,
    input  logic [BYTE_W-1:0]       wdata,
    output logic [BYTE_W*BYTES-1:0] instr
);

    for (genvar k = 0; k < BYTES; k++) begin : g_lane
        logic [BYTE_W-1:0] lane;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                lane <= '0;
            end else if (we && (sel == CNT_W'(k))) begin
                lane <= wdata;
            end
        end

        assign instr[BYTE_W*k +: BYTE_W] = lane;
    end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-serial instruction fetch with wait states, decoder hold and redirect
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               BYTES    = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    fetch_unit_if.master      bus,
    input  logic              redirect,
    input  logic [WIDTH-1:0]  redirect_pc,
    output logic [WIDTH-1:0]  pc,
    output logic              busy
);

    localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

    fetch_state_t      state;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  pc_q;
    logic [WIDTH-1:0]  instr_pc_q;
    logic              beat;

    // A redirect in the same cycle as a returned byte discards that byte.
    assign beat = (state == S_FETCH) && bus.mem_ready && !redirect;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc_q       <= RESET_PC;
            cnt        <= '0;
            instr_pc_q <= '0;
        end else if (redirect && (state != S_IDLE)) begin
            state <= S_FETCH;
            pc_q  <= redirect_pc;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: state <= S_FETCH;
                S_FETCH: begin
                    if (bus.mem_ready) begin
                        pc_q <= pc_q + WIDTH'(1);
                        if (cnt == '0) begin
                            instr_pc_q <= pc_q;
                        end
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= S_HOLD;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                S_HOLD: begin
                    if (bus.instr_ack) begin
                        state <= S_FETCH;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    instr_assembler #(.BYTES(BYTES)) u_asm (
        .clk   (clk),
        .reset (reset),
        .we    (beat),
        .sel   (cnt),
        .wdata (bus.mem_rdata),
        .instr (bus.instr)
    );

    assign pc              = pc_q;
    assign busy            = (state == S_FETCH);
    assign bus.mem_req     = (state == S_FETCH);
    assign bus.mem_addr    = pc_q;
    assign bus.instr_valid = (state == S_HOLD);
    assign bus.instr_pc    = instr_pc_q;

endmodule
